timer_tick_sched: RTL and testbench
===================================

// Module: timer_tick_sched
// PURPOSE
//  Avalon-MM master that owns the 100000-cycle interval timer. It enables the timer IRQ,
//  services each timeout (status read + clear), and keeps a free-running tick count.
//  It fans the tick out to NUM_CH divided event channels for periodic firmware/HW tasks.
//  Sits between the timer slave and the consumers that need periodic scheduling strobes.
// PARAMETERS
//  NUM_CH  4   number of scheduled event channels
//  DIV_W   8   width of each channel divider
//  TICK_W  32  width of tick_cnt
// PORTS
//  clk            in   1              system clock
//  reset_n        in   1              asynchronous, active-low reset
//  sched_en       in   1              1 = timer IRQ enabled and serviced; 0 = IRQ disabled
//  ch_div         in   NUM_CH*DIV_W   channel i divider in [i*DIV_W +: DIV_W]; fires every div+1 ticks
//  tmr_address    out  3              timer register address (0 status, 1 control)
//  tmr_chipselect out  1              timer chipselect
//  tmr_write_n    out  1              timer write strobe, active-low
//  tmr_writedata  out  16             timer write data
//  tmr_readdata   in   16             timer read data; registered in slave, valid 1 cycle after address
//  tmr_irq        in   1              timer interrupt, level
//  ch_tick        out  NUM_CH         1-cycle event strobe per channel
//  tick_cnt       out  TICK_W         serviced timeouts; wraps
//  spurious       out  1              sticky: IRQ seen but status TO bit (bit0) read as 0
//  busy           out  1              FSM not in IDLE/OFF
// BEHAVIOUR
//  Reset values: FSM=OFF; tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0;
//   ch_tick=0, tick_cnt=0, spurious=0, busy=0; channel counters=0.
//  tmr_* outputs are decoded only from the state register. There is no waitrequest;
//   every bus access is exactly 1 cycle.
//  States: OFF, EN_WR, IDLE, RD_ST, RD_WAIT, CLR_WR, DISPATCH, DIS_WR.
//  OFF:      bus idle. sched_en=1 -> EN_WR.
//  EN_WR:    cs=1, wr_n=0, addr=1, wdata=16'h0001. Loads each channel counter with ch_div[i].
//            -> IDLE.
//  IDLE:     sched_en=0 -> DIS_WR (has priority over irq). Else tmr_irq=1 -> RD_ST.
//  RD_ST:    cs=1, wr_n=1, addr=0 -> RD_WAIT.
//  RD_WAIT:  bus idle, addr held at 0; samples tmr_readdata[0].
//            1 -> CLR_WR. 0 -> set spurious, -> IDLE.
//  CLR_WR:   cs=1, wr_n=0, addr=0, wdata=0. The timer drops irq the next cycle. -> DISPATCH.
//  DISPATCH: ch_tick[i]=1 iff counter_i==0.
//            At exit: counter_i <= (==0) ? ch_div[i] : counter_i-1; tick_cnt += 1 (wraps to 0).
//            -> IDLE.
//  DIS_WR:   cs=1, wr_n=0, addr=1, wdata=0 -> OFF.
//  Latency: irq first seen in IDLE at cycle T -> RD_ST T+1, RD_WAIT T+2, CLR_WR T+3,
//   DISPATCH (ch_tick) T+4, IDLE T+5.
//  sched_en deasserted mid-service: the sequence completes through DISPATCH; DIS_WR follows
//   from IDLE. The IRQ is never left uncleared.
//  sched_en reasserted in DIS_WR/OFF: DIS_WR completes, then OFF -> EN_WR.
//  ch_div changes take effect only at a channel reload (EN_WR or a counter-zero in DISPATCH).
//  div=0 fires every tick. div=2^DIV_W-1 fires every 2^DIV_W ticks.
//  tick_cnt and spurious are cleared only by reset. They persist across sched_en cycling.
//  reset_n asserted mid-bus-cycle: outputs return to reset values immediately (async).
//  Timer control is rewritten on the next enable.
//  busy=1 in EN_WR, RD_ST, RD_WAIT, CLR_WR, DISPATCH, DIS_WR.
// TESTING
//  1. Reset release, sched_en=1 -> one write: addr1, data 0x0001, 1 cycle; then IDLE, bus idle.
//  2. irq at T, readdata=0x0003 -> RD_ST T+1, CLR_WR (addr0, data 0) T+3, ch_tick T+4,
//     tick_cnt=1.
//  3. ch_div={8'd0,8'd1,8'd2,8'd3}, 12 ticks -> ch0 fires every 4th tick (3 fires),
//     ch1 4, ch2 6, ch3 12.
//  4. irq with readdata[0]=0 -> no CLR_WR, no ch_tick, spurious=1 and stays 1; tick_cnt unchanged.
//  5. sched_en falls during RD_WAIT -> CLR_WR and DISPATCH still occur, then DIS_WR
//     (addr1, data 0), then OFF.
//  6. TICK_W=4, 17 ticks -> tick_cnt wraps 15->0 and reads 1. reset_n pulsed in CLR_WR ->
//     cs=0, wr_n=1 same cycle.

Source files
------------

// File: rtl/timer_tick_sched_if.sv
// Avalon-MM bus between the tick scheduler (master) and the interval timer (slave).
// Read data is registered in the slave and arrives one cycle after the address.
interface timer_tick_sched_if;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;

    modport master (
        output tmr_address,
        output tmr_chipselect,
        output tmr_write_n,
        output tmr_writedata,
        input  tmr_readdata,
        input  tmr_irq
    );

    modport slave (
        input  tmr_address,
        input  tmr_chipselect,
        input  tmr_write_n,
        input  tmr_writedata,
        output tmr_readdata,
        output tmr_irq
    );
endinterface

// File: rtl/timer_tick_sched.sv
// Interval-timer service FSM: enables the IRQ, reads/clears each timeout,
// counts ticks and fans them out to NUM_CH divided event strobes.
module timer_tick_sched #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 8,
    parameter int TICK_W = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sched_en,
    input  logic [NUM_CH*DIV_W-1:0] ch_div,
    timer_tick_sched_if.master      tmr,
    output logic [NUM_CH-1:0]       ch_tick,
    output logic [TICK_W-1:0]       tick_cnt,
    output logic                    spurious,
    output logic                    busy
);

    typedef enum logic [2:0] {
        OFF, EN_WR, IDLE, RD_ST,
        RD_WAIT, CLR_WR, DISPATCH, DIS_WR
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] cnt [NUM_CH];
    logic [NUM_CH-1:0] zero;

    always_comb begin
        zero = '0;
        for (int i = 0; i < NUM_CH; i++)
            zero[i] = (cnt[i] == '0);
    end

    // Bus outputs are registered together with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= OFF;
            tmr.tmr_chipselect  <= 1'b0;
            tmr.tmr_write_n     <= 1'b1;
            tmr.tmr_address     <= '0;
            tmr.tmr_writedata   <= '0;
            ch_tick             <= '0;
            tick_cnt            <= '0;
            spurious            <= 1'b0;
            busy                <= 1'b0;
            for (int i = 0; i < NUM_CH; i++)
                cnt[i] <= '0;
        end else begin
            tmr.tmr_chipselect <= 1'b0;
            tmr.tmr_write_n    <= 1'b1;
            tmr.tmr_writedata  <= '0;
            ch_tick            <= '0;
            unique case (state)
                OFF: begin
                    if (sched_en) begin
                        state              <= EN_WR;
                        tmr.tmr_chipselect <= 1'b1;
                        tmr.tmr_write_n    <= 1'b0;
                        tmr.tmr_address    <= 3'd1;
                        tmr.tmr_writedata  <= 16'h0001;
                        busy               <= 1'b1;
                    end
                end
                EN_WR: begin
                    for (int i = 0; i < NUM_CH; i++)
                        cnt[i] <= ch_div[i*DIV_W +: DIV_W];
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                IDLE: begin
                    if (!sched_en) begin
                        state              <= DIS_WR;
                        tmr.tmr_chipselect <= 1'b1;
                        tmr.tmr_write_n    <= 1'b0;
                        tmr.tmr_address    <= 3'd1;
                        busy               <= 1'b1;
                    end else if (tmr.tmr_irq) begin
                        state              <= RD_ST;
                        tmr.tmr_chipselect <= 1'b1;
                        tmr.tmr_address    <= 3'd0;
                        busy               <= 1'b1;
                    end
                end
                RD_ST: state <= RD_WAIT;
                RD_WAIT: begin
                    if (tmr.tmr_readdata[0]) begin
                        state              <= CLR_WR;
                        tmr.tmr_chipselect <= 1'b1;
                        tmr.tmr_write_n    <= 1'b0;
                        tmr.tmr_address    <= 3'd0;
                    end else begin
                        spurious <= 1'b1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                end
                CLR_WR: begin
                    state   <= DISPATCH;
                    ch_tick <= zero;
                end
                DISPATCH: begin
                    // Zero counters fire this cycle and reload the current divider.
                    for (int i = 0; i < NUM_CH; i++)
                        cnt[i] <= zero[i] ? ch_div[i*DIV_W +: DIV_W]
                                          : cnt[i] - DIV_W'(1);
                    tick_cnt <= tick_cnt + TICK_W'(1);
                    state    <= IDLE;
                    busy     <= 1'b0;
                end
                DIS_WR: begin
                    state <= OFF;
                    busy  <= 1'b0;
                end
                default: state <= OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_tick_sched.sv
// Directed bench for timer_tick_sched; a tick/channel model built from
// the service latency rules is compared against the DUT every cycle.
module tb_timer_tick_sched;
    localparam int NC = 4;
    localparam int DW = 8;
    localparam int TW = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             sched_en = 1'b0;
    logic [NC*DW-1:0] ch_div = '0;
    logic [NC-1:0]    ch_tick;
    logic [TW-1:0]    tick_cnt;
    logic             spurious;
    logic             busy;

    timer_tick_sched_if bus ();

    timer_tick_sched #(.NUM_CH(NC), .DIV_W(DW), .TICK_W(TW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sched_en (sched_en),
        .ch_div   (ch_div),
        .tmr      (bus.master),
        .ch_tick  (ch_tick),
        .tick_cnt (tick_cnt),
        .spurious (spurious),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic          e_cs = 1'b0;
    logic          e_wr_n = 1'b1;
    logic [2:0]    e_addr = '0;
    bit            e_achk = 1'b1;
    logic [15:0]   e_wdata = '0;
    bit            e_wchk = 1'b1;
    logic [NC-1:0] e_tick = '0;
    logic          e_busy = 1'b0;

    int m_tick = 0;
    bit m_spur = 1'b0;
    int m_n [NC];
    int m_p [NC];
    int fires [NC];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cs", 32'(bus.tmr_chipselect), 32'(e_cs));
        chk("wr_n", 32'(bus.tmr_write_n), 32'(e_wr_n));
        if (e_achk) chk("addr", 32'(bus.tmr_address), 32'(e_addr));
        if (e_wchk) chk("wdata", 32'(bus.tmr_writedata), 32'(e_wdata));
        chk("ch_tick", 32'(ch_tick), 32'(e_tick));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("tick_cnt", 32'(tick_cnt), 32'(m_tick % 16));
        chk("spurious", 32'(spurious), 32'(m_spur));
        for (int i = 0; i < NC; i++)
            if (ch_tick[i]) fires[i]++;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        e_cs = 1'b0; e_wr_n = 1'b1; e_achk = 1'b0;
        e_wchk = 1'b0; e_tick = '0; e_busy = 1'b0;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
        e_cs = 1'b1; e_wr_n = 1'b0; e_achk = 1'b1; e_addr = a;
        e_wchk = 1'b1; e_wdata = d; e_tick = '0; e_busy = 1'b1;
    endtask

    task automatic reload_all();
        for (int i = 0; i < NC; i++) begin
            m_n[i] = 0;
            m_p[i] = int'(ch_div[i*DW +: DW]) + 1;
        end
    endtask

    task automatic clear_fires();
        for (int i = 0; i < NC; i++) fires[i] = 0;
    endtask

    // From OFF: one control write, then IDLE.
    task automatic enable();
        sched_en = 1'b1;
        nxt();
        bus_wr(3'd1, 16'h0001);
        reload_all();
        nxt();
        bus_idle();
    endtask

    // From IDLE (or with sched_en already low in IDLE): DIS_WR then OFF.
    task automatic disable_sched();
        sched_en = 1'b0;
        nxt();
        bus_wr(3'd1, 16'h0000);
        nxt();
        bus_idle();
    endtask

    // Called in an IDLE cycle T; returns in the following IDLE cycle.
    task automatic service(input logic [15:0] rd, input bit drop_en,
                           input bit rst_clr);
        bus.tmr_readdata = rd;
        bus.tmr_irq = 1'b1;
        nxt();
        e_cs = 1'b1; e_wr_n = 1'b1; e_achk = 1'b1; e_addr = 3'd0;
        e_wchk = 1'b0; e_busy = 1'b1;
        nxt();
        e_cs = 1'b0;
        if (drop_en) sched_en = 1'b0;
        if (!rd[0]) begin
            bus.tmr_irq = 1'b0;
            nxt();
            m_spur = 1'b1;
            bus_idle();
            return;
        end
        nxt();
        bus_wr(3'd0, 16'h0000);
        if (rst_clr) begin
            #1 reset_n = 1'b0;
            #1;
            chk("rst_cs", 32'(bus.tmr_chipselect), 32'd0);
            chk("rst_wr_n", 32'(bus.tmr_write_n), 32'd1);
            bus.tmr_irq = 1'b0;
            sched_en = 1'b0;
            m_tick = 0;
            m_spur = 1'b0;
            bus_idle();
            e_achk = 1'b1; e_addr = 3'd0;
            e_wchk = 1'b1; e_wdata = 16'h0000;
            return;
        end
        nxt();
        bus.tmr_irq = 1'b0;
        e_cs = 1'b0; e_wr_n = 1'b1; e_achk = 1'b0;
        e_wchk = 1'b0; e_busy = 1'b1;
        for (int i = 0; i < NC; i++)
            e_tick[i] = (m_n[i] + 1 == m_p[i]);
        nxt();
        m_tick++;
        for (int i = 0; i < NC; i++) begin
            if (e_tick[i]) begin
                m_n[i] = 0;
                m_p[i] = int'(ch_div[i*DW +: DW]) + 1;
            end else begin
                m_n[i]++;
            end
        end
        bus_idle();
    endtask

    initial begin
        bus.tmr_irq = 1'b0;
        bus.tmr_readdata = '0;
        clear_fires();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs0", 32'(bus.tmr_chipselect), 32'd0);
        chk("rst_addr0", 32'(bus.tmr_address), 32'd0);
        chk("rst_tick_cnt0", 32'(tick_cnt), 32'd0);
        reset_n = 1'b1;
        nxt();

        enable();
        nxt();
        nxt();

        service(16'h0003, 1'b0, 1'b0);
        chk("t2_tick_cnt", 32'(tick_cnt), 32'd1);

        disable_sched();
        ch_div = {8'd0, 8'd1, 8'd2, 8'd3};
        enable();
        clear_fires();
        repeat (12) service(16'h0001, 1'b0, 1'b0);
        chk("t3_ch0", 32'(fires[0]), 32'd3);
        chk("t3_ch1", 32'(fires[1]), 32'd4);
        chk("t3_ch2", 32'(fires[2]), 32'd6);
        chk("t3_ch3", 32'(fires[3]), 32'd12);

        ch_div = '0;
        clear_fires();
        repeat (4) service(16'h0001, 1'b0, 1'b0);
        chk("reload_ch0", 32'(fires[0]), 32'd1);
        chk("reload_ch1", 32'(fires[1]), 32'd2);
        chk("reload_ch2", 32'(fires[2]), 32'd3);
        chk("reload_ch3", 32'(fires[3]), 32'd4);

        service(16'h0002, 1'b0, 1'b0);
        chk("t4_spurious", 32'(spurious), 32'd1);
        chk("t4_tick_cnt", 32'(tick_cnt), 32'd1);
        service(16'h0001, 1'b0, 1'b0);
        chk("t4_sticky", 32'(spurious), 32'd1);

        service(16'h0001, 1'b1, 1'b0);
        disable_sched();
        chk("t5_tick_cnt", 32'(tick_cnt), 32'd3);

        enable();
        sched_en = 1'b0;
        nxt();
        bus_wr(3'd1, 16'h0000);
        sched_en = 1'b1;
        nxt();
        bus_idle();
        enable();

        disable_sched();
        ch_div = {8'd0, 8'd0, 8'd0, 8'd255};
        enable();
        clear_fires();
        repeat (255) service(16'h0001, 1'b0, 1'b0);
        chk("div255_early", 32'(fires[0]), 32'd0);
        service(16'h0001, 1'b0, 1'b0);
        chk("div255_fire", 32'(fires[0]), 32'd1);
        chk("div0_fire", 32'(fires[3]), 32'd256);

        service(16'h0001, 1'b0, 1'b1);
        nxt();
        reset_n = 1'b1;
        nxt();
        chk("t6_spur_clr", 32'(spurious), 32'd0);
        enable();
        repeat (17) service(16'h0001, 1'b0, 1'b0);
        chk("t6_wrap", 32'(tick_cnt), 32'd1);
        nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
